cache_mem_responder: RTL and testbench
======================================

// Module: cache_mem_responder
// PURPOSE
//   Memory-side responder for the cache-to-memory line interface (mem_read/mem_write/
//   mem_addr/mem_wdata/mem_rdata/mem_ready). It sits opposite an I/D cache controller.
//   It answers 128-bit line requests after a programmable latency from a local line array.
//   It replaces the behavioural slow memory in synthesizable system builds.
// PARAMETERS
//   LATENCY   4    cycles from request acceptance to mem_ready; legal range >=1
//   DEPTH     256  lines in the backing array; power of two; index = mem_addr[log2(DEPTH)-1:0]
//   LINE_W    128  line width in bits
//   ADDR_W    28   line address width
// PORTS
//   clk         in   1       rising-edge clock
//   proc_reset  in   1       asynchronous, active-high reset
//   mem_read    in   1       line read request; held by requester until mem_ready
//   mem_write   in   1       line write request; held by requester until mem_ready
//   mem_addr    in   ADDR_W  line address; sampled at acceptance
//   mem_wdata   in   LINE_W  write line; sampled at acceptance
//   mem_rdata   out  LINE_W  read line; valid while mem_ready=1, then held
//   mem_ready   out  1       one-cycle completion pulse
//   init_we     in   1       backdoor preload write; only honoured in IDLE
//   init_addr   in   ADDR_W  backdoor line index
//   init_data   in   LINE_W  backdoor line data
//   proto_err   out  1       sticky protocol-violation flag
// BEHAVIOUR
//   Reset (async): state=IDLE, mem_ready=0, mem_rdata=0, proto_err=0. Array contents are
//     not cleared.
//   FSM IDLE -> BUSY -> RESP -> IDLE:
//     IDLE: if (mem_read|mem_write) at edge: latch addr, wdata, op; go BUSY.
//       With LATENCY=1, go directly to RESP.
//     BUSY: counter counts LATENCY-1 cycles, then goes RESP.
//     RESP: mem_ready=1 for exactly one cycle; then IDLE.
//   Timing: request first high in IDLE cycle t -> mem_ready high in cycle t+LATENCY only.
//   Read: mem_rdata <= array[latched index], registered into RESP.
//     Held unchanged after RESP until the next read response.
//   Write: array[latched index] <= latched wdata, committed on the edge leaving RESP.
//     mem_rdata unchanged.
//   mem_read & mem_write both high at acceptance: write wins; proto_err set.
//   Request dropped, or addr/op changed, during BUSY: ignored (latched values used);
//     proto_err set.
//   The requester deasserts its request in the cycle after mem_ready.
//     A request still high in the first IDLE cycle is accepted as a new request.
//   Address bits above log2(DEPTH) are ignored; indices wrap modulo DEPTH.
//   init_we in IDLE with no request: array[init_addr mod DEPTH] <= init_data.
//     init_we outside IDLE, or together with a request: dropped; proto_err set.
//   Reset mid-operation: transaction aborted, no array write, mem_ready stays 0.
//   proto_err clears only on proc_reset.
// STRUCTURE
//   Package cache_mem_pkg: LINE_W/ADDR_W constants, state enum {IDLE,BUSY,RESP},
//     latency counter width function.
//   Sub-module mem_line_array: single-port synchronous DEPTH x LINE_W array,
//     registered read, write enable; arbitration between init and commit lives in the top.
//   Top holds the FSM, latch registers, latency counter and error logic.
// TESTING
//   LATENCY=4; preload line 5=128'hA5..A5; read addr 5 at t -> mem_ready only at t+4,
//     mem_rdata=A5..A5.
//   Write addr 7 data 128'h1234; read addr 7 -> 128'h1234 returned; line 5 unchanged.
//   Read addr 28'h0000105 with DEPTH=256 -> data of line 5 (wrap/index masking).
//   mem_read&mem_write together, addr 9, data D -> write of D commits, proto_err=1,
//     sticky until reset.
//   proc_reset pulsed during BUSY of a write to line 3 -> no mem_ready, line 3 keeps old
//     value, outputs zero.
//   Back-to-back reads of 2 then 4, request dropped the cycle after ready -> two pulses
//     LATENCY+1 cycles apart, correct data.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared constants and types for the cache-side memory responder.
// Line and address widths are fixed here. The latency counter width is derived from LATENCY.
package cache_mem_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // The counter is loaded with LATENCY-2 and counts down to zero.
    function automatic int cnt_width(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat - 1);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Single-port synchronous line store with a registered, enable-gated read port.
// The read register holds its value between reads, so it can drive the response data directly.
module mem_line_array
    import cache_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic              i_we,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic              i_re,
    output logic [LINE_W-1:0] o_rdata
);

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    // Contents are deliberately left alone by reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder that answers cache line requests from a local array after a fixed latency.
//   state   | meaning
//   IDLE    | waiting; accepts a request, or a backdoor preload when no request is present
//   BUSY    | latency down-counter running on the latched request
//   RESP    | mem_ready pulse; a latched write commits on the edge that leaves this state
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [LINE_W-1:0] init_data,
    output logic              proto_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_t            r_state;
    op_t               r_op;
    logic              r_ready;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_req;
    op_t               w_op;
    logic              w_to_resp;
    logic              w_arr_re;
    logic              w_commit;
    logic              w_init;
    logic              w_arr_we;
    logic [IDX_W-1:0]  w_arr_addr;
    logic [LINE_W-1:0] w_arr_wdata;
    logic [LINE_W-1:0] w_arr_rdata;
    logic              w_err_now;
    logic              w_unused_init_hi;

    assign w_req = mem_read | mem_write;
    assign w_op  = mem_write ? OP_WRITE : OP_READ;

    // The array read is issued on the edge that enters RESP, so the data is valid while mem_ready is high.
    assign w_to_resp = ((r_state == ST_BUSY) && (r_cnt == '0)) ||
                       ((LATENCY == 1) && (r_state == ST_IDLE) && w_req);
    assign w_arr_re  = w_to_resp &&
                       (((r_state == ST_BUSY) && (r_op == OP_READ)) ||
                        ((r_state == ST_IDLE) && (w_op == OP_READ)));

    assign w_commit    = (r_state == ST_RESP) && (r_op == OP_WRITE);
    assign w_init      = (r_state == ST_IDLE) && !w_req && init_we;
    assign w_arr_we    = w_commit | w_init;
    assign w_arr_wdata = w_commit ? r_wdata : init_data;
    assign w_arr_addr  = (r_state != ST_IDLE) ? r_addr[IDX_W-1:0] :
                         (w_req ? mem_addr[IDX_W-1:0] : init_addr[IDX_W-1:0]);

    assign w_err_now = (init_we && !w_init) ||
                       ((r_state == ST_IDLE) && mem_read && mem_write) ||
                       ((r_state == ST_BUSY) && (!w_req || (mem_addr != r_addr) || (w_op != r_op)));

    assign w_unused_init_hi = ^init_addr[ADDR_W-1:IDX_W];

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_READ;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_ready <= 1'b0;
            if (w_err_now) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_op    <= w_op;
                        r_addr  <= mem_addr;
                        r_wdata <= mem_wdata;
                        r_cnt   <= CNT_LOAD;
                        if (LATENCY == 1) begin
                            r_state <= ST_RESP;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_line_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (proc_reset),
        .i_addr  (w_arr_addr),
        .i_we    (w_arr_we),
        .i_wdata (w_arr_wdata),
        .i_re    (w_arr_re),
        .o_rdata (w_arr_rdata)
    );

    assign mem_rdata = w_arr_rdata;
    assign mem_ready = r_ready;
    assign proto_err = r_err;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: expected read lines are queued at request time and popped on mem_ready.
module tb_cache_mem_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         init_we;
    logic [27:0]  init_addr;
    logic [127:0] init_data;
    logic         proto_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_ready_cyc = 0;

    logic [127:0] model [256];
    logic [127:0] sb_q [$];
    logic [127:0] last_rdata = '0;

    cache_mem_responder #(.LATENCY(LAT), .DEPTH(256)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [127:0] d);
        init_we   = 1'b1;
        init_addr = 28'(idx);
        init_data = d;
        tick();
        init_we   = 1'b0;
        model[idx % 256] = d;
    endtask

    task automatic sb_pop_check(input string tag);
        logic [127:0] exp;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 128'd0, 128'd1);
        end else begin
            exp = sb_q.pop_front();
            check_val({tag, "_rdata"}, mem_rdata, exp);
            last_rdata = exp;
        end
    endtask

    // Drives a request, waits for mem_ready and scores it; returns in the RESP cycle with the request dropped.
    task automatic do_req(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] d, input int exp_lat, input string tag);
        int n;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = d;
        if (wr) model[addr[7:0]] = d;
        else    sb_q.push_back(model[addr[7:0]]);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_ready && n < 20);
        check_val({tag, "_lat"}, 128'(n), 128'(exp_lat));
        last_ready_cyc = cyc;
        if (!wr) sb_pop_check(tag);
        else     check_val({tag, "_rdata_held"}, mem_rdata, last_rdata);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic req_full(input logic rd, input logic wr, input logic [27:0] addr,
                            input logic [127:0] d, input string tag);
        do_req(rd, wr, addr, d, LAT, tag);
        tick();
        check_val({tag, "_pulse_end"}, 128'(mem_ready), 128'd0);
        check_val({tag, "_hold"}, mem_rdata, last_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        proc_reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        tick(); tick();
        proc_reset = 1'b0;
        tick();
        check_val("rst_ready", 128'(mem_ready), 128'd0);
        check_val("rst_rdata", mem_rdata, 128'd0);
        check_val("rst_err", 128'(proto_err), 128'd0);

        preload(5, {16{8'hA5}});
        preload(7, 128'hDEAD_0007);
        preload(3, 128'h3333_3333);
        preload(2, 128'h2222_0002);
        preload(4, 128'h4444_0004);
        preload(6, 128'h6666_0006);
        preload(9, 128'h9999_0009);

        req_full(1'b1, 1'b0, 28'd5, '0, "rd5");
        req_full(1'b0, 1'b1, 28'd7, 128'h1234, "wr7");
        req_full(1'b1, 1'b0, 28'd7, '0, "rd7");
        req_full(1'b1, 1'b0, 28'd5, '0, "rd5_again");
        check_val("no_err_yet", 128'(proto_err), 128'd0);
        req_full(1'b1, 1'b0, 28'h0000105, '0, "rd_wrap");

        req_full(1'b1, 1'b1, 28'd9, 128'hD00D_F00D, "rdwr9");
        check_val("rdwr_err", 128'(proto_err), 128'd1);
        req_full(1'b1, 1'b0, 28'd9, '0, "rd9");
        check_val("err_sticky", 128'(proto_err), 128'd1);

        // Reset in the middle of a write to line 3.
        mem_write = 1'b1; mem_addr = 28'd3; mem_wdata = 128'hBAD0_BAD0;
        tick(); tick();
        proc_reset = 1'b1;
        #2;
        check_val("midrst_ready", 128'(mem_ready), 128'd0);
        check_val("midrst_rdata", mem_rdata, 128'd0);
        check_val("midrst_err", 128'(proto_err), 128'd0);
        mem_write = 1'b0;
        last_rdata = '0;
        tick();
        proc_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("midrst_no_ready", 128'(mem_ready), 128'd0);
        end
        req_full(1'b1, 1'b0, 28'd3, '0, "rd3_after_rst");

        do_req(1'b1, 1'b0, 28'd2, '0, LAT, "b2b_rd2");
        c1 = last_ready_cyc;
        do_req(1'b1, 1'b0, 28'd4, '0, LAT + 1, "b2b_rd4");
        check_val("b2b_gap", 128'(last_ready_cyc - c1), 128'(LAT + 1));
        tick();
        check_val("b2b_pulse_end", 128'(mem_ready), 128'd0);
        check_val("b2b_err", 128'(proto_err), 128'd0);

        // Address change and a preload attempt while BUSY: latched address wins, preload is dropped.
        mem_read = 1'b1; mem_addr = 28'd5;
        sb_q.push_back(model[5]);
        tick();
        mem_addr  = 28'd7;
        init_we   = 1'b1; init_addr = 28'd6; init_data = 128'hFFFF;
        tick();
        init_we = 1'b0;
        tick(); tick();
        check_val("busy_chg_ready", 128'(mem_ready), 128'd1);
        sb_pop_check("busy_chg");
        mem_read = 1'b0;
        tick();
        check_val("busy_chg_err", 128'(proto_err), 128'd1);
        req_full(1'b1, 1'b0, 28'd6, '0, "rd6_not_overwritten");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
